picomips_seq: RTL

picoMIPS control sequencer: the master end of the program-counter control interface. Each cycle it decodes the current instruction, holds the zero flag and a small run/wait/halt state machine, and drives PCincr, PCrelbranch and Branchaddr into the PC. It also drives the register-file write enable. It sits between program memory output and the PC, and gives the core its single-cycle sequencing plus a button-paced WAIT instruction.

---
 rtl/picomips_pkg.sv | 33 +++
 rtl/picomips_seq_sync2.sv | 28 ++
 rtl/picomips_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcode and sequencer state encodings, plus the
// PC/instruction width defaults used by both the PC and the sequencer.
package picomips_pkg;

   localparam int PSIZE_DEF = 5;
   localparam int ISIZE_DEF = 16;

   typedef enum logic [3:0] {
      OPC_NOP  = 4'd0,
      OPC_ADD  = 4'd1,
      OPC_ADDI = 4'd2,
      OPC_SUB  = 4'd3,
      OPC_SUBI = 4'd4,
      OPC_MULI = 4'd5,
      OPC_BEQ  = 4'd6,
      OPC_BNE  = 4'd7,
      OPC_BRA  = 4'd8,
      OPC_WAIT = 4'd9,
      OPC_HALT = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      ST_RUN          = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_WAIT_RELEASE = 2'd2,
      ST_HALT         = 2'd3
   } state_e;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return (opc >= OPC_ADD) && (opc <= OPC_MULI);
   endfunction

endpackage

// File: rtl/picomips_seq_sync2.sv
// Two-flop synchronizer for the go push-button; only built when GO_SYNC_EN
// is defined, since the default build feeds go straight through.
`ifdef GO_SYNC_EN
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   // metastability filter: r_meta may go metastable, r_q is the clean copy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule
`endif

// File: rtl/picomips_seq.sv
// picoMIPS control sequencer: instruction decode, zero flag and the
// run/wait/halt FSM driving the PC. GO_SYNC_EN adds a 2-flop go synchronizer.
module picomips_seq
   import picomips_pkg::*;
#(
   parameter int Psize = PSIZE_DEF,
   parameter int Isize = ISIZE_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [Isize-1:0] instr,
   input  logic             alu_zero,
   input  logic             go,
   output logic             PCincr,
   output logic             PCrelbranch,
   output logic [Psize-1:0] Branchaddr,
   output logic             regw,
   output logic             waiting,
   output logic             halted
);

   state_e      r_state;
   state_e      w_next;
   logic        r_zflag;
   logic        r_waiting;
   logic        r_halted;
   logic        w_go_s;
   logic        w_pcincr;
   logic        w_relbr;
   logic        w_regw;
   logic        w_zload;
   logic [3:0]  w_opc;
   logic        w_unused_bits;

   assign w_opc         = instr[Isize-1 -: 4];
   assign w_unused_bits = ^instr[Isize-5:Psize];

`ifdef GO_SYNC_EN
   sync2 u_sync2 (
      .clk   (clk),
      .reset (reset),
      .i_d   (go),
      .o_q   (w_go_s)
   );
`else
   assign w_go_s = go;
`endif

   // state, flag and the registered status decodes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_zflag   <= 1'b0;
         r_waiting <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         r_state   <= w_next;
         if (w_zload) begin
            r_zflag <= alu_zero;
         end
         r_waiting <= (w_next == ST_WAIT_PRESS) || (w_next == ST_WAIT_RELEASE);
         r_halted  <= (w_next == ST_HALT);
      end
   end

   // next-state and PC strobe decode
   always_comb begin
      w_next   = r_state;
      w_pcincr = 1'b0;
      w_relbr  = 1'b0;
      w_regw   = 1'b0;
      w_zload  = 1'b0;
      case (r_state)
         ST_RUN: begin
            case (w_opc)
               OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI, OPC_MULI: begin
                  w_regw   = 1'b1;
                  w_pcincr = 1'b1;
                  w_zload  = is_alu_op(w_opc);
               end
               OPC_BEQ: begin
                  if (r_zflag) w_relbr = 1'b1;
                  else         w_pcincr = 1'b1;
               end
               OPC_BNE: begin
                  if (!r_zflag) w_relbr = 1'b1;
                  else          w_pcincr = 1'b1;
               end
               OPC_BRA:  w_relbr = 1'b1;
               OPC_WAIT: w_next  = ST_WAIT_PRESS;
               OPC_HALT: w_next  = ST_HALT;
               default:  w_pcincr = 1'b1;
            endcase
         end
         ST_WAIT_PRESS: begin
            if (w_go_s) w_next = ST_WAIT_RELEASE;
            else        w_next = ST_WAIT_PRESS;
         end
         ST_WAIT_RELEASE: begin
            if (!w_go_s) begin
               w_pcincr = 1'b1;
               w_next   = ST_RUN;
            end else begin
               w_next   = ST_WAIT_RELEASE;
            end
         end
         ST_HALT: w_next = ST_HALT;
         default: w_next = ST_RUN;
      endcase
   end

   // reset overrides the decode so no strobe escapes while the PC is clearing
   assign PCincr      = w_pcincr & ~reset;
   assign PCrelbranch = w_relbr & ~reset;
   assign regw        = w_regw & ~reset;
   assign Branchaddr  = instr[Psize-1:0];
   assign waiting     = r_waiting;
   assign halted      = r_halted;

endmodule
